// File: rtl/neogeo_mem_pkg.sv
// Shared memory-map constants and SDRAM arbiter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neogeo_mem_pkg;

    localparam int SDRAM_AW = 25;

    localparam logic [SDRAM_AW-1:0] NEOGEO_BASE_PROM = 25'h0000000;
    localparam logic [SDRAM_AW-1:0] NEOGEO_BASE_WRAM = 25'h0200000;
    localparam logic [SDRAM_AW-1:0] NEOGEO_BASE_SROM = 25'h0210000;
    localparam logic [SDRAM_AW-1:0] NEOGEO_BASE_Z80  = 25'h0300000;

    typedef enum logic [2:0] {
        IDLE,
        RFSH,
        ACC68,
        HOLD68,
        ACCZ80
    } arb_state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer with a sticky pending flag.
// Latency: pending rises INTERVAL cycles after reset or the previous expiry.
// Backpressure: expiries while pending is already set are dropped.
module sdram_refresh_timer #(
    parameter int INTERVAL = 384
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    output logic pending
);

    localparam int CW = $clog2(INTERVAL + 1);

    logic [CW-1:0] cnt;

    // The reload happens on the step that would land on zero, so the
    // period is exactly INTERVAL cycles; a new expiry beats a same-cycle clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= CW'(INTERVAL);
            pending <= 1'b0;
        end else if (cnt == CW'(1)) begin
            cnt     <= CW'(INTERVAL);
            pending <= 1'b1;
        end else begin
            cnt <= cnt - CW'(1);
            if (clear) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// Shares the SDRAM port between 68K zones, Z80 ROM fetches and refresh.
// Latency: SDRAM_REQ one cycle after grant; READY / Z80_ACK one cycle after SDRAM_ACK.
// Backpressure: REQ held until SDRAM_ACK or TIMEOUT; 68K stalls on SDRAM_READY, Z80 on Z80_ACK.
module sdram_bus_arbiter
    import neogeo_mem_pkg::*;
#(
    parameter int                  REFRESH_INTERVAL = 384,
    parameter int                  TIMEOUT          = 31,
    parameter int                  Z80_MAX_SKIP     = 4,
    parameter logic [SDRAM_AW-1:0] BASE_PROM        = NEOGEO_BASE_PROM,
    parameter logic [SDRAM_AW-1:0] BASE_WRAM        = NEOGEO_BASE_WRAM,
    parameter logic [SDRAM_AW-1:0] BASE_SROM        = NEOGEO_BASE_SROM,
    parameter logic [SDRAM_AW-1:0] BASE_Z80         = NEOGEO_BASE_Z80
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                nAS,
    input  logic                M68K_RW,
    input  logic                nUDS,
    input  logic                nLDS,
    input  logic [22:0]         M68K_ADDR,
    input  logic [15:0]         M68K_DIN,
    input  logic                nROM_ZONE,
    input  logic                nWRAM_ZONE,
    input  logic                nSROM_ZONE,
    output logic [15:0]         M68K_DOUT,
    output logic                SDRAM_READY,
    input  logic                Z80_REQ,
    input  logic [19:0]         Z80_ADDR,
    output logic [7:0]          Z80_DOUT,
    output logic                Z80_ACK,
    output logic                SDRAM_REQ,
    output logic                SDRAM_WE,
    output logic                SDRAM_RFSH,
    output logic [SDRAM_AW-1:0] SDRAM_ADDR,
    output logic [1:0]          SDRAM_BE,
    output logic [15:0]         SDRAM_WDATA,
    input  logic [15:0]         SDRAM_RDATA,
    input  logic                SDRAM_ACK
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(Z80_MAX_SKIP + 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT);
    localparam logic [SW-1:0] SKIP_MAX = SW'(Z80_MAX_SKIP);

    arb_state_t          state, state_nxt;
    logic                served, aborted, abort_nxt;
    logic [SW-1:0]       skip;
    logic [TW-1:0]       to_cnt, to_nxt;
    logic                rfsh_pend, rfsh_clear;
    logic                req68, z80_pend, z80_forced, to_expire;
    logic                grant_68, grant_z80;
    logic [SDRAM_AW-1:0] addr68, addr_z80;

    logic                req_nxt, we_nxt, rfsh_nxt, ready_nxt, zack_nxt;
    logic [SDRAM_AW-1:0] addr_nxt;
    logic [1:0]          be_nxt;
    logic [15:0]         wdata_nxt, dout68_nxt;
    logic [7:0]          doutz_nxt;

    wire unused_addr_bits = &{1'b1, M68K_ADDR[22:20]};

    sdram_refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) u_rfsh_timer (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (rfsh_clear),
        .pending (rfsh_pend)
    );

    // Z80_REQ stays high through the ACK cycle; masking it avoids a re-grant.
    assign req68      = ~nAS & ~(nROM_ZONE & nWRAM_ZONE & nSROM_ZONE) & ~served;
    assign z80_pend   = Z80_REQ & ~Z80_ACK;
    assign z80_forced = z80_pend && (skip == SKIP_MAX);
    assign to_expire  = (to_cnt == TW'(1));
    assign addr_z80   = BASE_Z80 + {5'b0, Z80_ADDR};

    always_comb begin
        if (!nROM_ZONE) begin
            addr68 = BASE_PROM + {4'b0, M68K_ADDR[19:0], 1'b0};
        end else if (!nWRAM_ZONE) begin
            addr68 = BASE_WRAM + {9'b0, M68K_ADDR[14:0], 1'b0};
        end else begin
            addr68 = BASE_SROM + {8'b0, M68K_ADDR[15:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt  = state;
        req_nxt    = SDRAM_REQ;
        we_nxt     = SDRAM_WE;
        rfsh_nxt   = SDRAM_RFSH;
        addr_nxt   = SDRAM_ADDR;
        be_nxt     = SDRAM_BE;
        wdata_nxt  = SDRAM_WDATA;
        dout68_nxt = M68K_DOUT;
        doutz_nxt  = Z80_DOUT;
        ready_nxt  = 1'b0;
        zack_nxt   = 1'b0;
        to_nxt     = to_cnt;
        abort_nxt  = aborted;
        grant_68   = 1'b0;
        grant_z80  = 1'b0;
        rfsh_clear = 1'b0;

        case (state)
            IDLE: begin
                abort_nxt = 1'b0;
                to_nxt    = TO_LOAD;
                if (rfsh_pend) begin
                    state_nxt = RFSH;
                    req_nxt   = 1'b1;
                    rfsh_nxt  = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = '0;
                    be_nxt    = 2'b00;
                end else if (z80_forced || (z80_pend && !req68)) begin
                    grant_z80 = 1'b1;
                    state_nxt = ACCZ80;
                    req_nxt   = 1'b1;
                    we_nxt    = 1'b0;
                    addr_nxt  = addr_z80;
                    be_nxt    = Z80_ADDR[0] ? 2'b10 : 2'b01;
                end else if (req68) begin
                    grant_68  = 1'b1;
                    state_nxt = ACC68;
                    req_nxt   = 1'b1;
                    we_nxt    = ~M68K_RW;
                    addr_nxt  = addr68;
                    be_nxt    = ~{nUDS, nLDS};
                    wdata_nxt = M68K_DIN;
                end
            end
            RFSH: begin
                if (SDRAM_ACK || to_expire) begin
                    state_nxt  = IDLE;
                    req_nxt    = 1'b0;
                    rfsh_nxt   = 1'b0;
                    rfsh_clear = 1'b1;
                end else begin
                    to_nxt = to_cnt - TW'(1);
                end
            end
            ACC68: begin
                if (SDRAM_ACK || to_expire) begin
                    req_nxt = 1'b0;
                    we_nxt  = 1'b0;
                    // A strobe that went away mid-cycle gets no data and no READY.
                    if (aborted || nAS) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt  = HOLD68;
                        ready_nxt  = 1'b1;
                        dout68_nxt = SDRAM_ACK ? SDRAM_RDATA : 16'hFFFF;
                    end
                end else begin
                    to_nxt = to_cnt - TW'(1);
                    if (nAS) begin
                        abort_nxt = 1'b1;
                    end
                end
            end
            HOLD68: begin
                if (nAS) begin
                    state_nxt = IDLE;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            ACCZ80: begin
                if (SDRAM_ACK || to_expire) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                    zack_nxt  = 1'b1;
                    if (SDRAM_ACK) begin
                        doutz_nxt = SDRAM_BE[1] ? SDRAM_RDATA[15:8] : SDRAM_RDATA[7:0];
                    end else begin
                        doutz_nxt = 8'hFF;
                    end
                end else begin
                    to_nxt = to_cnt - TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
                rfsh_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            SDRAM_REQ   <= 1'b0;
            SDRAM_WE    <= 1'b0;
            SDRAM_RFSH  <= 1'b0;
            SDRAM_ADDR  <= '0;
            SDRAM_BE    <= 2'b00;
            SDRAM_WDATA <= '0;
            M68K_DOUT   <= '0;
            SDRAM_READY <= 1'b0;
            Z80_DOUT    <= '0;
            Z80_ACK     <= 1'b0;
            to_cnt      <= '0;
            aborted     <= 1'b0;
            served      <= 1'b0;
            skip        <= '0;
        end else begin
            state       <= state_nxt;
            SDRAM_REQ   <= req_nxt;
            SDRAM_WE    <= we_nxt;
            SDRAM_RFSH  <= rfsh_nxt;
            SDRAM_ADDR  <= addr_nxt;
            SDRAM_BE    <= be_nxt;
            SDRAM_WDATA <= wdata_nxt;
            M68K_DOUT   <= dout68_nxt;
            SDRAM_READY <= ready_nxt;
            Z80_DOUT    <= doutz_nxt;
            Z80_ACK     <= zack_nxt;
            to_cnt      <= to_nxt;
            aborted     <= abort_nxt;
            if (nAS) begin
                served <= 1'b0;
            end else if (grant_68) begin
                served <= 1'b1;
            end
            if (grant_z80) begin
                skip <= '0;
            end else if (grant_68 && z80_pend && skip != SKIP_MAX) begin
                skip <= skip + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed bench for sdram_bus_arbiter: reset, 68K read/write, refresh priority,
// Z80 fairness and request timeout, with hand-computed expectations.
module tb_sdram_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        nAS, M68K_RW, nUDS, nLDS;
    logic [22:0] M68K_ADDR;
    logic [15:0] M68K_DIN;
    logic        nROM_ZONE, nWRAM_ZONE, nSROM_ZONE;
    logic [15:0] M68K_DOUT;
    logic        SDRAM_READY;
    logic        Z80_REQ;
    logic [19:0] Z80_ADDR;
    logic [7:0]  Z80_DOUT;
    logic        Z80_ACK;
    logic        SDRAM_REQ, SDRAM_WE, SDRAM_RFSH;
    logic [24:0] SDRAM_ADDR;
    logic [1:0]  SDRAM_BE;
    logic [15:0] SDRAM_WDATA, SDRAM_RDATA;
    logic        SDRAM_ACK;

    int checks   = 0;
    int failures = 0;

    sdram_bus_arbiter dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .nAS         (nAS),
        .M68K_RW     (M68K_RW),
        .nUDS        (nUDS),
        .nLDS        (nLDS),
        .M68K_ADDR   (M68K_ADDR),
        .M68K_DIN    (M68K_DIN),
        .nROM_ZONE   (nROM_ZONE),
        .nWRAM_ZONE  (nWRAM_ZONE),
        .nSROM_ZONE  (nSROM_ZONE),
        .M68K_DOUT   (M68K_DOUT),
        .SDRAM_READY (SDRAM_READY),
        .Z80_REQ     (Z80_REQ),
        .Z80_ADDR    (Z80_ADDR),
        .Z80_DOUT    (Z80_DOUT),
        .Z80_ACK     (Z80_ACK),
        .SDRAM_REQ   (SDRAM_REQ),
        .SDRAM_WE    (SDRAM_WE),
        .SDRAM_RFSH  (SDRAM_RFSH),
        .SDRAM_ADDR  (SDRAM_ADDR),
        .SDRAM_BE    (SDRAM_BE),
        .SDRAM_WDATA (SDRAM_WDATA),
        .SDRAM_RDATA (SDRAM_RDATA),
        .SDRAM_ACK   (SDRAM_ACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        nAS = 1'b1; M68K_RW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        M68K_ADDR = '0; M68K_DIN = '0;
        nROM_ZONE = 1'b1; nWRAM_ZONE = 1'b1; nSROM_ZONE = 1'b1;
        Z80_REQ = 1'b0; Z80_ADDR = '0;
        SDRAM_RDATA = '0; SDRAM_ACK = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        idle_inputs();
        repeat (3) tick();
        RESET = 1'b0;
    endtask

    task automatic wait_req(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (SDRAM_REQ === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_ack(input logic [15:0] d);
        SDRAM_ACK = 1'b1;
        SDRAM_RDATA = d;
        tick();
        SDRAM_ACK = 1'b0;
        SDRAM_RDATA = '0;
    endtask

    task automatic test_reset();
        logic [71:0] outs;
        int low_cnt;
        bit ok;
        RESET = 1'b1;
        idle_inputs();
        tick(); tick();
        outs = {M68K_DOUT, SDRAM_READY, Z80_DOUT, Z80_ACK, SDRAM_REQ, SDRAM_WE,
                SDRAM_RFSH, SDRAM_ADDR, SDRAM_BE, SDRAM_WDATA};
        checks++;
        if (outs !== 72'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        tick();
        RESET = 1'b0;
        low_cnt = 0;
        for (int i = 0; i < 383; i++) begin
            tick();
            if (SDRAM_REQ === 1'b0) low_cnt++;
        end
        checks++;
        if (low_cnt !== 383) begin
            failures++;
            $display("FAIL reset_no_req: REQ low %0d cycles required 383", low_cnt);
        end
        wait_req(8, ok);
        checks++;
        if (!ok || SDRAM_RFSH !== 1'b1) begin
            failures++;
            $display("FAIL first_refresh: req_seen=%0d RFSH=%b required 1/1", ok, SDRAM_RFSH);
        end
        pulse_ack(16'h0000);
        checks++;
        if (SDRAM_REQ !== 1'b0 || SDRAM_RFSH !== 1'b0) begin
            failures++;
            $display("FAIL refresh_done: REQ=%b RFSH=%b required 0/0", SDRAM_REQ, SDRAM_RFSH);
        end
    endtask

    task automatic test_rom_read();
        do_reset();
        nAS = 1'b0; nROM_ZONE = 1'b0; M68K_RW = 1'b1; nUDS = 1'b0; nLDS = 1'b0;
        M68K_ADDR = 23'h00091A;
        tick();
        checks++;
        if (SDRAM_REQ !== 1'b1) begin
            failures++;
            $display("FAIL rom_req_latency: REQ=%b required 1", SDRAM_REQ);
        end
        checks++;
        if (SDRAM_ADDR !== 25'h0001234) begin
            failures++;
            $display("FAIL rom_addr: got %h required 0001234", SDRAM_ADDR);
        end
        checks++;
        if ({SDRAM_WE, SDRAM_BE} !== 3'b011) begin
            failures++;
            $display("FAIL rom_we_be: got %b required 011", {SDRAM_WE, SDRAM_BE});
        end
        repeat (3) tick();
        checks++;
        if (SDRAM_READY !== 1'b0 || SDRAM_REQ !== 1'b1) begin
            failures++;
            $display("FAIL rom_wait: READY=%b REQ=%b required 0/1", SDRAM_READY, SDRAM_REQ);
        end
        tick();
        pulse_ack(16'hA55A);
        checks++;
        if (M68K_DOUT !== 16'hA55A || SDRAM_READY !== 1'b1) begin
            failures++;
            $display("FAIL rom_data: DOUT=%h READY=%b required A55A/1", M68K_DOUT, SDRAM_READY);
        end
        checks++;
        if (SDRAM_REQ !== 1'b0) begin
            failures++;
            $display("FAIL rom_req_drop: REQ=%b required 0", SDRAM_REQ);
        end
        tick();
        checks++;
        if (SDRAM_READY !== 1'b1) begin
            failures++;
            $display("FAIL rom_ready_hold: READY=%b required 1", SDRAM_READY);
        end
        nAS = 1'b1; nROM_ZONE = 1'b1;
        tick();
        checks++;
        if (SDRAM_READY !== 1'b0) begin
            failures++;
            $display("FAIL rom_ready_release: READY=%b required 0", SDRAM_READY);
        end
    endtask

    task automatic test_wram_write();
        do_reset();
        nAS = 1'b0; nWRAM_ZONE = 1'b0; M68K_RW = 1'b0; nUDS = 1'b0; nLDS = 1'b1;
        M68K_ADDR = 23'h00C321;   // byte 0x18642 wraps to WRAM offset 0x8642
        M68K_DIN = 16'hBEEF;
        tick();
        checks++;
        if ({SDRAM_REQ, SDRAM_WE, SDRAM_BE} !== 4'b1110) begin
            failures++;
            $display("FAIL wram_ctrl: REQ/WE/BE=%b required 1110", {SDRAM_REQ, SDRAM_WE, SDRAM_BE});
        end
        checks++;
        if (SDRAM_WDATA !== 16'hBEEF || SDRAM_ADDR !== 25'h0208642) begin
            failures++;
            $display("FAIL wram_data_addr: WDATA=%h ADDR=%h required BEEF/0208642", SDRAM_WDATA, SDRAM_ADDR);
        end
        pulse_ack(16'h0000);
        checks++;
        if (SDRAM_READY !== 1'b1) begin
            failures++;
            $display("FAIL wram_ready: READY=%b required 1", SDRAM_READY);
        end
        nAS = 1'b1; nWRAM_ZONE = 1'b1;
        tick();
    endtask

    task automatic test_refresh_vs_68k();
        bit ok;
        do_reset();
        repeat (368) tick();
        Z80_REQ = 1'b1; Z80_ADDR = 20'h12345;
        wait_req(4, ok);
        checks++;
        if (!ok || SDRAM_ADDR !== 25'h0312345 || SDRAM_BE !== 2'b10 || SDRAM_RFSH !== 1'b0) begin
            failures++;
            $display("FAIL z80_addr: seen=%0d ADDR=%h BE=%b RFSH=%b required 1/0312345/10/0",
                     ok, SDRAM_ADDR, SDRAM_BE, SDRAM_RFSH);
        end
        repeat (3) tick();
        nAS = 1'b0; nROM_ZONE = 1'b0; M68K_RW = 1'b1; nUDS = 1'b0; nLDS = 1'b0;
        M68K_ADDR = 23'h000010;
        // Hold the Z80 cycle open until the refresh expiry has certainly happened.
        repeat (20) tick();
        pulse_ack(16'hC35A);
        checks++;
        if (Z80_ACK !== 1'b1 || Z80_DOUT !== 8'hC3) begin
            failures++;
            $display("FAIL z80_odd_byte: ACK=%b DOUT=%h required 1/C3", Z80_ACK, Z80_DOUT);
        end
        Z80_REQ = 1'b0;
        tick();
        checks++;
        if (SDRAM_REQ !== 1'b1 || SDRAM_RFSH !== 1'b1 || Z80_ACK !== 1'b0) begin
            failures++;
            $display("FAIL rfsh_first: REQ=%b RFSH=%b Z80_ACK=%b required 1/1/0", SDRAM_REQ, SDRAM_RFSH, Z80_ACK);
        end
        pulse_ack(16'h0000);
        checks++;
        if (SDRAM_READY !== 1'b0) begin
            failures++;
            $display("FAIL rfsh_no_ready: READY=%b required 0", SDRAM_READY);
        end
        wait_req(4, ok);
        checks++;
        if (!ok || SDRAM_RFSH !== 1'b0 || SDRAM_ADDR !== 25'h0000020 || SDRAM_READY !== 1'b0) begin
            failures++;
            $display("FAIL m68k_after_rfsh: seen=%0d RFSH=%b ADDR=%h READY=%b required 1/0/0000020/0",
                     ok, SDRAM_RFSH, SDRAM_ADDR, SDRAM_READY);
        end
        pulse_ack(16'h1234);
        checks++;
        if (SDRAM_READY !== 1'b1 || M68K_DOUT !== 16'h1234) begin
            failures++;
            $display("FAIL m68k_after_rfsh_data: READY=%b DOUT=%h required 1/1234", SDRAM_READY, M68K_DOUT);
        end
        nAS = 1'b1; nROM_ZONE = 1'b1;
        tick();
    endtask

    task automatic test_fairness();
        bit ok;
        int grants68;
        int acks;
        do_reset();
        Z80_REQ = 1'b1; Z80_ADDR = 20'h00100;
        nAS = 1'b0; nROM_ZONE = 1'b0; M68K_RW = 1'b1; nUDS = 1'b0; nLDS = 1'b0;
        M68K_ADDR = 23'h000100;
        grants68 = 0;
        ok = 1'b0;
        for (int g = 0; g < 6; g++) begin
            wait_req(6, ok);
            if (!ok || SDRAM_ADDR[24:20] == 5'h03) break;
            grants68++;
            pulse_ack(16'h0100);
            nAS = 1'b1;
            tick();
            nAS = 1'b0;
            M68K_ADDR = M68K_ADDR + 23'd1;
        end
        checks++;
        if (!ok || grants68 !== 4) begin
            failures++;
            $display("FAIL fair_grants: req_seen=%0d 68K grants before Z80=%0d required 4", ok, grants68);
        end
        checks++;
        if (SDRAM_ADDR !== 25'h0300100 || SDRAM_BE !== 2'b01) begin
            failures++;
            $display("FAIL fair_z80_addr: ADDR=%h BE=%b required 0300100/01", SDRAM_ADDR, SDRAM_BE);
        end
        pulse_ack(16'h7E81);
        checks++;
        if (Z80_DOUT !== 8'h81) begin
            failures++;
            $display("FAIL fair_z80_byte: DOUT=%h required 81", Z80_DOUT);
        end
        acks = (Z80_ACK === 1'b1) ? 1 : 0;
        Z80_REQ = 1'b0;
        tick();
        if (Z80_ACK === 1'b1) acks++;
        tick();
        if (Z80_ACK === 1'b1) acks++;
        checks++;
        if (acks !== 1) begin
            failures++;
            $display("FAIL fair_z80_pulse: Z80_ACK high %0d cycles required 1", acks);
        end
        checks++;
        if (SDRAM_REQ !== 1'b1 || SDRAM_ADDR !== 25'h0000208) begin
            failures++;
            $display("FAIL fair_68k_resume: REQ=%b ADDR=%h required 1/0000208", SDRAM_REQ, SDRAM_ADDR);
        end
        pulse_ack(16'h0000);
        nAS = 1'b1; nROM_ZONE = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int hi;
        do_reset();
        nAS = 1'b0; nSROM_ZONE = 1'b0; M68K_RW = 1'b1; nUDS = 1'b0; nLDS = 1'b0;
        M68K_ADDR = 23'h020005;   // byte 0x4000A wraps to SROM offset 0x0000A
        wait_req(4, ok);
        checks++;
        if (!ok || SDRAM_ADDR !== 25'h021000A) begin
            failures++;
            $display("FAIL srom_addr: seen=%0d ADDR=%h required 1/021000A", ok, SDRAM_ADDR);
        end
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (SDRAM_REQ === 1'b1) hi++;
            else break;
        end
        checks++;
        if (hi !== 31) begin
            failures++;
            $display("FAIL timeout_len: REQ high %0d cycles required 31", hi);
        end
        checks++;
        if (SDRAM_READY !== 1'b1 || M68K_DOUT !== 16'hFFFF) begin
            failures++;
            $display("FAIL timeout_data: READY=%b DOUT=%h required 1/FFFF", SDRAM_READY, M68K_DOUT);
        end
        nAS = 1'b1; nSROM_ZONE = 1'b1;
        tick();
        checks++;
        if (SDRAM_READY !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release: READY=%b required 0", SDRAM_READY);
        end
        pulse_ack(16'h5555);
        tick();
        checks++;
        if (SDRAM_REQ !== 1'b0 || SDRAM_READY !== 1'b0 || M68K_DOUT !== 16'hFFFF) begin
            failures++;
            $display("FAIL stray_ack: REQ=%b READY=%b DOUT=%h required 0/0/FFFF", SDRAM_REQ, SDRAM_READY, M68K_DOUT);
        end
        nAS = 1'b0; nROM_ZONE = 1'b0;
        M68K_ADDR = 23'h1FFFFF;   // byte 0x3FFFFE wraps to ROM offset 0x1FFFFE
        wait_req(4, ok);
        checks++;
        if (!ok || SDRAM_ADDR !== 25'h01FFFFE) begin
            failures++;
            $display("FAIL after_timeout_addr: seen=%0d ADDR=%h required 1/01FFFFE", ok, SDRAM_ADDR);
        end
        pulse_ack(16'h0F0F);
        checks++;
        if (SDRAM_READY !== 1'b1 || M68K_DOUT !== 16'h0F0F) begin
            failures++;
            $display("FAIL after_timeout_data: READY=%b DOUT=%h required 1/0F0F", SDRAM_READY, M68K_DOUT);
        end
        nAS = 1'b1; nROM_ZONE = 1'b1;
        tick();
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_rom_read();
        test_wram_write();
        test_refresh_vs_68k();
        test_fairness();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
